// File: rtl/ddr_tip_pkg.sv
// DDR training IP shared types and helpers.
// Phase vectors are indexed by DFI phase, bit 0 = p0.
package ddr_tip_pkg;
  localparam int NUM_PHASES = 4;

  typedef logic [NUM_PHASES-1:0] phase_t;

  localparam int DEF_LAT_CYC = 1;
  localparam int DEF_LAT_PH  = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic logic [2:0] popcnt4(input phase_t v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction
endpackage

// File: rtl/phase_delay_line.sv
// Programmable phase-resolution delay: rotate by lat_ph with carry,
// then a cycle delay line with taps at lat_cyc and lat_cyc-1.
module phase_delay_line
  import ddr_tip_pkg::*;
#(
  parameter int  MAX_LAT = 16,
  localparam int LW      = clog2(MAX_LAT + 1)
) (
  input  logic          sclk,
  input  logic          srst_n,
  input  phase_t        din,
  input  logic [LW-1:0] lat_cyc,
  input  logic [1:0]    lat_ph,
  output phase_t        tap,
  output phase_t        tap_early
);
  logic [2*NUM_PHASES-1:0] rot;
  phase_t carry_q;
  phase_t din_rot;
  phase_t dl [1:MAX_LAT];

  assign rot     = {{NUM_PHASES{1'b0}}, din} << lat_ph;
  assign din_rot = rot[NUM_PHASES-1:0] | carry_q;

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      carry_q <= '0;
      for (int k = 1; k <= MAX_LAT; k++) dl[k] <= '0;
    end else begin
      carry_q <= rot[2*NUM_PHASES-1:NUM_PHASES];
      dl[1]   <= din_rot;
      for (int k = 2; k <= MAX_LAT; k++) dl[k] <= dl[k-1];
    end
  end

  // At latency 1 the lookahead only sees carried phases; the rest
  // would need the live input, which must not reach the outputs.
  always_comb begin
    tap       = '0;
    tap_early = carry_q;
    for (int k = 1; k <= MAX_LAT; k++)
      if (lat_cyc == LW'(k)) tap = dl[k];
    for (int k = 2; k <= MAX_LAT; k++)
      if (lat_cyc == LW'(k)) tap_early = dl[k-1];
  end
endmodule

// File: rtl/dq_rd_gate_valid_gen.sv
// Read-path gate and DFI read-valid generation with latency shadowing
// and in-flight tracking; outputs decode from registered state only.
module dq_rd_gate_valid_gen
  import ddr_tip_pkg::*;
#(
  parameter int  IOG_DQS_LANES  = 9,
  parameter int  MAX_LAT_CYCLES = 16,
  parameter int  RD_CAPTURE_LAT = 2,
  localparam int LW = clog2(MAX_LAT_CYCLES + 1),
  localparam int CW = clog2(NUM_PHASES *
                      (MAX_LAT_CYCLES + RD_CAPTURE_LAT + 2) + 1)
) (
  input  logic                     sclk,
  input  logic                     srst_n,
  input  logic                     dfi_rddata_en_p0,
  input  logic                     dfi_rddata_en_p1,
  input  logic                     dfi_rddata_en_p2,
  input  logic                     dfi_rddata_en_p3,
  input  logic [LW-1:0]            rd_lat_cycles,
  input  logic [1:0]               rd_lat_phase,
  output logic [IOG_DQS_LANES-1:0] rd_gate_p0,
  output logic [IOG_DQS_LANES-1:0] rd_gate_p1,
  output logic [IOG_DQS_LANES-1:0] rd_gate_p2,
  output logic [IOG_DQS_LANES-1:0] rd_gate_p3,
  output logic                     dfi_rddata_valid_w0,
  output logic                     dfi_rddata_valid_w1,
  output logic                     dfi_rddata_valid_w2,
  output logic                     dfi_rddata_valid_w3,
  output logic                     rd_idle,
  output logic                     cfg_pending
);
  phase_t        en;
  phase_t        tap;
  phase_t        tap_early;
  phase_t        vld;
  phase_t        gate;
  phase_t        vp [RD_CAPTURE_LAT];
  logic [LW-1:0] cyc_c;
  logic [LW-1:0] sh_cyc;
  logic [LW-1:0] sh_cyc_d;
  logic [1:0]    sh_ph;
  logic [1:0]    sh_ph_d;
  logic [CW-1:0] inflight;
  logic          load;
  logic          pend_q;

  assign en = {dfi_rddata_en_p3, dfi_rddata_en_p2,
               dfi_rddata_en_p1, dfi_rddata_en_p0};

  always_comb begin
    cyc_c = rd_lat_cycles;
    if (rd_lat_cycles == '0)
      cyc_c = LW'(1);
    else if (rd_lat_cycles > LW'(MAX_LAT_CYCLES))
      cyc_c = LW'(MAX_LAT_CYCLES);
  end

  assign rd_idle  = (inflight == '0);
  assign load     = rd_idle && (en == '0);
  assign sh_cyc_d = load ? cyc_c : sh_cyc;
  assign sh_ph_d  = load ? rd_lat_phase : sh_ph;

  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      sh_cyc <= LW'(DEF_LAT_CYC);
      sh_ph  <= 2'(DEF_LAT_PH);
      pend_q <= 1'b0;
    end else begin
      sh_cyc <= sh_cyc_d;
      sh_ph  <= sh_ph_d;
      pend_q <= (cyc_c != sh_cyc_d) || (rd_lat_phase != sh_ph_d);
    end
  end

  assign cfg_pending = pend_q;

  phase_delay_line #(
    .MAX_LAT   (MAX_LAT_CYCLES)
  ) u_dly (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .din       (en),
    .lat_cyc   (sh_cyc),
    .lat_ph    (sh_ph),
    .tap       (tap),
    .tap_early (tap_early)
  );

  // vp[0] doubles as the previous-cycle tap for the p0 preamble
  always_ff @(posedge sclk) begin
    if (!srst_n) begin
      for (int k = 0; k < RD_CAPTURE_LAT; k++) vp[k] <= '0;
      inflight <= '0;
    end else begin
      vp[0] <= tap;
      for (int k = 1; k < RD_CAPTURE_LAT; k++) vp[k] <= vp[k-1];
      inflight <= inflight + CW'(popcnt4(en)) - CW'(popcnt4(vld));
    end
  end

  assign vld = vp[RD_CAPTURE_LAT-1];

  assign gate[0] = vp[0][3] | tap[0] | tap[1];
  assign gate[1] = tap[0] | tap[1] | tap[2];
  assign gate[2] = tap[1] | tap[2] | tap[3];
  assign gate[3] = tap[2] | tap[3] | tap_early[0];

  assign rd_gate_p0 = {IOG_DQS_LANES{gate[0]}};
  assign rd_gate_p1 = {IOG_DQS_LANES{gate[1]}};
  assign rd_gate_p2 = {IOG_DQS_LANES{gate[2]}};
  assign rd_gate_p3 = {IOG_DQS_LANES{gate[3]}};

  assign dfi_rddata_valid_w0 = vld[0];
  assign dfi_rddata_valid_w1 = vld[1];
  assign dfi_rddata_valid_w2 = vld[2];
  assign dfi_rddata_valid_w3 = vld[3];
endmodule

// File: tb/tb_dq_rd_gate_valid_gen.sv
// Directed vector bench for dq_rd_gate_valid_gen.
// Each scenario restarts from reset at its cycle 0.
module tb_dq_rd_gate_valid_gen;
  import ddr_tip_pkg::*;

  localparam int L = 9;

  typedef struct {
    int         scn;
    int         cyc;
    logic       rst;
    phase_t     en;
    logic [4:0] lc;
    logic [1:0] lp;
  } stim_t;

  typedef struct {
    int     scn;
    int     cyc;
    phase_t g;
    phase_t v;
    logic   ci;
    logic   idle;
    logic   cp;
    logic   pend;
  } exp_t;

  logic         sclk = 1'b0;
  logic         srst_n = 1'b0;
  phase_t       en = '0;
  logic [4:0]   rd_lat_cycles = 5'd1;
  logic [1:0]   rd_lat_phase = 2'd0;
  logic [L-1:0] g0, g1, g2, g3;
  logic         v0, v1, v2, v3;
  logic         rd_idle, cfg_pending;

  int n_cmp = 0;
  int n_bad = 0;

  stim_t stim[$];
  exp_t  expv[$];

  always #5 sclk = ~sclk;

  dq_rd_gate_valid_gen dut (
    .sclk                (sclk),
    .srst_n              (srst_n),
    .dfi_rddata_en_p0    (en[0]),
    .dfi_rddata_en_p1    (en[1]),
    .dfi_rddata_en_p2    (en[2]),
    .dfi_rddata_en_p3    (en[3]),
    .rd_lat_cycles       (rd_lat_cycles),
    .rd_lat_phase        (rd_lat_phase),
    .rd_gate_p0          (g0),
    .rd_gate_p1          (g1),
    .rd_gate_p2          (g2),
    .rd_gate_p3          (g3),
    .dfi_rddata_valid_w0 (v0),
    .dfi_rddata_valid_w1 (v1),
    .dfi_rddata_valid_w2 (v2),
    .dfi_rddata_valid_w3 (v3),
    .rd_idle             (rd_idle),
    .cfg_pending         (cfg_pending)
  );

  function automatic logic [4*L-1:0] gexp(input phase_t g);
    return {{L{g[3]}}, {L{g[2]}}, {L{g[1]}}, {L{g[0]}}};
  endfunction

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [4*L-1:0] act,
                     input logic [4*L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input phase_t g,
                         input phase_t v);
    chk({nm, " gate"}, {g3, g2, g1, g0}, gexp(g));
    chk({nm, " valid"}, (4*L)'({v3, v2, v1, v0}), (4*L)'(v));
  endtask

  task automatic run_scn(input int s);
    logic [4:0] lc;
    logic [1:0] lp;
    logic       rst;
    phase_t     g;
    phase_t     v;
    string      nm;
    lc = 5'd1;
    lp = 2'd0;
    for (int c = 0; c < 32; c++) begin
      en  = '0;
      rst = (c == 0);
      foreach (stim[i]) begin
        if (stim[i].scn == s && stim[i].cyc == c) begin
          en  = stim[i].en;
          lc  = stim[i].lc;
          lp  = stim[i].lp;
          rst = rst | stim[i].rst;
        end
      end
      srst_n        = !rst;
      rd_lat_cycles = lc;
      rd_lat_phase  = lp;
      if (c >= 1) begin
        nm = $sformatf("s%0d c%0d", s, c);
        g  = '0;
        v  = '0;
        foreach (expv[i]) begin
          if (expv[i].scn == s && expv[i].cyc == c) begin
            g = expv[i].g;
            v = expv[i].v;
            if (expv[i].ci)
              chk({nm, " idle"}, (4*L)'(rd_idle),
                  (4*L)'(expv[i].idle));
            if (expv[i].cp)
              chk({nm, " pend"}, (4*L)'(cfg_pending),
                  (4*L)'(expv[i].pend));
          end
        end
        chk_out(nm, g, v);
        if (c == 1) begin
          chk({nm, " rst idle"}, (4*L)'(rd_idle), (4*L)'(1'b1));
          chk({nm, " rst pend"}, (4*L)'(cfg_pending), '0);
        end
      end
      step();
    end
  endtask

  initial begin
    // {scn, cyc, rst, en, lat_cyc, lat_ph}
    stim.push_back('{1, 0, 1'b0, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{1, 10, 1'b0, 4'b0010, 5'd2, 2'd0});
    stim.push_back('{2, 0, 1'b0, 4'b0000, 5'd2, 2'd3});
    stim.push_back('{2, 10, 1'b0, 4'b0100, 5'd2, 2'd3});
    stim.push_back('{3, 0, 1'b0, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{3, 10, 1'b0, 4'b1111, 5'd2, 2'd0});
    stim.push_back('{3, 11, 1'b0, 4'b1111, 5'd2, 2'd0});
    stim.push_back('{4, 0, 1'b0, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{4, 10, 1'b0, 4'b0001, 5'd2, 2'd0});
    stim.push_back('{4, 11, 1'b0, 4'b0000, 5'd5, 2'd0});
    stim.push_back('{4, 17, 1'b0, 4'b0001, 5'd5, 2'd0});
    stim.push_back('{5, 0, 1'b0, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{5, 10, 1'b0, 4'b0010, 5'd2, 2'd0});
    stim.push_back('{5, 13, 1'b1, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{6, 0, 1'b0, 4'b0000, 5'd0, 2'd0});
    stim.push_back('{6, 10, 1'b0, 4'b0001, 5'd0, 2'd0});
    stim.push_back('{7, 0, 1'b0, 4'b0000, 5'd20, 2'd0});
    stim.push_back('{7, 10, 1'b0, 4'b1000, 5'd20, 2'd0});
    stim.push_back('{8, 0, 1'b0, 4'b0000, 5'd2, 2'd0});
    stim.push_back('{8, 10, 1'b0, 4'b1001, 5'd2, 2'd0});

    // {scn, cyc, gate, valid, chk_idle, idle, chk_pend, pend}
    expv.push_back('{1, 11, 4'b0000, 4'b0000, 1, 0, 0, 0});
    expv.push_back('{1, 12, 4'b0111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{1, 14, 4'b0000, 4'b0010, 0, 0, 0, 0});
    expv.push_back('{1, 15, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{2, 13, 4'b0111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{2, 15, 4'b0000, 4'b0010, 1, 0, 0, 0});
    expv.push_back('{2, 16, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{3, 11, 4'b1000, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{3, 12, 4'b1111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{3, 13, 4'b1111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{3, 14, 4'b0001, 4'b1111, 0, 0, 0, 0});
    expv.push_back('{3, 15, 4'b0000, 4'b1111, 1, 0, 0, 0});
    expv.push_back('{3, 16, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{4, 11, 4'b1000, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{4, 12, 4'b0011, 4'b0000, 0, 0, 1, 1});
    expv.push_back('{4, 14, 4'b0000, 4'b0001, 0, 0, 0, 0});
    expv.push_back('{4, 15, 4'b0000, 4'b0000, 1, 1, 1, 1});
    expv.push_back('{4, 16, 4'b0000, 4'b0000, 0, 0, 1, 0});
    expv.push_back('{4, 21, 4'b1000, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{4, 22, 4'b0011, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{4, 24, 4'b0000, 4'b0001, 0, 0, 0, 0});
    expv.push_back('{4, 25, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{5, 12, 4'b0111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{5, 14, 4'b0000, 4'b0000, 1, 1, 1, 0});
    expv.push_back('{6, 5, 4'b0000, 4'b0000, 0, 0, 1, 0});
    expv.push_back('{6, 11, 4'b0011, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{6, 13, 4'b0000, 4'b0001, 0, 0, 0, 0});
    expv.push_back('{6, 14, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{7, 5, 4'b0000, 4'b0000, 0, 0, 1, 0});
    expv.push_back('{7, 26, 4'b1100, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{7, 27, 4'b0001, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{7, 28, 4'b0000, 4'b1000, 0, 0, 0, 0});
    expv.push_back('{7, 29, 4'b0000, 4'b0000, 1, 1, 0, 0});
    expv.push_back('{8, 11, 4'b1000, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{8, 12, 4'b1111, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{8, 13, 4'b0001, 4'b0000, 0, 0, 0, 0});
    expv.push_back('{8, 14, 4'b0000, 4'b1001, 0, 0, 0, 0});

    step();
    for (int s = 1; s <= 8; s++) run_scn(s);

    // Latency 1/1: en_p3 carries into p0 two cycles later,
    // and the carry register supplies the p3 preamble.
    srst_n        = 1'b0;
    rd_lat_cycles = 5'd1;
    rd_lat_phase  = 2'd1;
    step();
    srst_n = 1'b1;
    repeat (3) step();
    en = 4'b1000;
    chk_out("lat1ph1 c0", 4'b0000, 4'b0000);
    step();
    en = '0;
    chk_out("lat1ph1 c1", 4'b1000, 4'b0000);
    step();
    chk_out("lat1ph1 c2", 4'b0011, 4'b0000);
    chk("lat1ph1 c2 idle", (4*L)'(rd_idle), '0);
    step();
    chk_out("lat1ph1 c3", 4'b0000, 4'b0000);
    step();
    chk_out("lat1ph1 c4", 4'b0000, 4'b0001);
    step();
    chk_out("lat1ph1 c5", 4'b0000, 4'b0000);
    chk("lat1ph1 c5 idle", (4*L)'(rd_idle), (4*L)'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dq_rd_gate_valid_gen.md
Name: dq_rd_gate_valid_gen

Overview:
Read-direction companion to the write-path DQ/DQS output-enable logic in the DDR training IP (TIP).
- Takes the 4-phase DFI read enables (dfi_rddata_en_p0..p3) and delays them by a programmable read latency, resolved to phase granularity.
- Drives per-lane IOG read-capture gates, widened by one phase before and after each burst for DQS preamble/postamble.
- Generates dfi_rddata_valid_w0..w3 aligned to captured data.
- Tracks in-flight read phases, so latency changes are applied only when the read path is idle.

Parameters:
- IOG_DQS_LANES, 9, number of byte lanes (width of each gate output).
- MAX_LAT_CYCLES, 16, maximum rd_lat_cycles supported (depth of the delay line, in sclk cycles).
- RD_CAPTURE_LAT, 2, fixed sclk cycles from gate phase to data valid at the DFI.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- srst_n  in  1  synchronous active-low reset.
- dfi_rddata_en_p0..p3  in  1 each  read-data enable per phase, from the controller.
- rd_lat_cycles  in  clog2(MAX_LAT_CYCLES+1)  read latency, whole sclk cycles; legal range 1..MAX_LAT_CYCLES.
- rd_lat_phase  in  2  additional read latency in phases, 0..3.
- rd_gate_p0..p3  out  IOG_DQS_LANES each  per-lane IOG read-capture gate per phase; all ones or all zeros.
- dfi_rddata_valid_w0..w3  out  1 each  DFI read-data valid per phase.
- rd_idle  out  1  high when the in-flight count is zero.
- cfg_pending  out  1  high while an input latency differs from the active (shadow) latency.

Behaviour:
- Clock and reset are fixed: one clock, sclk; reset srst_n is synchronous and active-low.
- Reset, taken at a sclk edge with srst_n low:
  - clears the delay line, the carry register and the in-flight counter;
  - shadow latency = 1 cycle, 0 phases;
  - all gates and valids = 0; rd_idle = 1; cfg_pending = 0.
- Reset mid-burst flushes everything. No valid pulse may appear after reset is released for reads issued before reset.
- Shadow latency:
  - Loads rd_lat_cycles/rd_lat_phase on any cycle where the in-flight count is 0 and no dfi_rddata_en_pN is high.
  - Otherwise it holds its value, and cfg_pending = (inputs != shadow).
  - rd_lat_cycles = 0 or > MAX_LAT_CYCLES is clamped to 1 or MAX_LAT_CYCLES respectively.
- Delay, using absolute phase index 4t+N (cycle t, phase N):
  - An enable at input phase N of cycle t appears at phase X = 4t+N+D, where D = 4*lat_cyc+lat_ph (shadow values).
  - Implementation: phase-rotate by lat_ph with a 4-bit carry register into the next cycle, then a cycle delay line of 4-bit entries.
  - Taps at lat_cyc and lat_cyc-1 provide one cycle of lookahead for the preamble.
- Gate:
  - rd_gate at phase P = all ones iff the delayed enable is high at P-1, P or P+1. A single enable therefore yields a 3-phase gate.
  - Gate windows from adjacent bursts merge with no gap.
  - Bursts separated by exactly 2 idle phases produce one continuous gate.
- Valid: dfi_rddata_valid at phase P iff the delayed enable is high at P-4*RD_CAPTURE_LAT, i.e. same phase, RD_CAPTURE_LAT cycles after the gate centre.
- In-flight counter:
  - Per cycle: += popcount(input enables), -= popcount(valid outputs).
  - Width is clog2(4*(MAX_LAT_CYCLES+RD_CAPTURE_LAT+2)+1); it never overflows or underflows by construction.
  - Simultaneous increment and decrement are applied in the same cycle.
- Outputs: gates and valids are decoded combinationally from registered state; no combinational path from the DFI inputs.

Decomposition:
- Shared package `ddr_tip_pkg` holds:
  - NUM_PHASES = 4;
  - phase-vector typedef logic [3:0];
  - clog2 function;
  - default latency constants.
- One natural sub-module, `phase_delay_line`: a 4-bit-wide programmable cycle delay with phase rotate and carry, and dual taps (lat, lat-1). It is reusable for the write-leveling path.

Test Plan:
- RD_CAPTURE_LAT=2, latency 2/0; en_p1 at cycle 10 -> rd_gate_p0,p1,p2 = 9'h1FF at cycle 12, all other gates 0; dfi_rddata_valid_w1 = 1 at cycle 14 only.
- Latency 2/3; en_p2 at cycle 10 (X = 53 = cycle 13, p1) -> gate p0..p2 at cycle 13; valid_w1 at cycle 15; rd_idle returns to 1 at cycle 16.
- Latency 2/0; all four enables high at cycles 10 and 11 -> gate covers cycle 11 p3 continuously through cycle 14 p0; valid all phases at cycles 14 and 15; in-flight count peaks at 8 and returns to 0.
- Set rd_lat_cycles=5 at cycle 11 while a read is in flight -> cfg_pending=1, and the returning data still uses latency 2; the new latency loads once idle; the next read's valid arrives 7 cycles after issue.
- srst_n low at cycle 13 during the scenario-1 burst -> all gates and valids 0 from cycle 14; no valid at cycle 14 after release; rd_idle=1.
- rd_lat_cycles=0 -> behaves exactly as 1; en_p0 at cycle 10 -> valid_w0 at cycle 13.
